demux_1to2_buffered: RTL
========================

Name: demux_1to2_buffered

Overview:
- Inverse of the CPU's 2:1 select path: takes one WIDTH-bit producer stream and steers each word to one of two consumer lanes, chosen by select bit S.
- Each lane has a DEPTH-entry FIFO and valid/ready handshakes on both sides. A stalled consumer therefore back-pressures only words aimed at its own lane.
- Sits between the datapath result bus and two write-back or peripheral consumers in the 24-bit CPU.

Parameters:
- WIDTH, 24, data word width in bits.
- DEPTH, 2, entries per lane FIFO; power of two, at least 2.
- CNT_W, 16, width of the per-lane accepted-word counters.

Ports:
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Hyrja  in  WIDTH  input data word.
- HyrjaValid  in  1  producer has a word on Hyrja.
- HyrjaReady  out  1  block can accept a word for the lane currently selected by S.
- S  in  1  lane select, sampled with the word; S=1 routes to lane 0, S=0 routes to lane 1.
- Dalja0  out  WIDTH  lane 0 head word.
- Dalja0Valid  out  1  lane 0 FIFO not empty.
- Dalja0Ready  in  1  lane 0 consumer takes the head word.
- Dalja1  out  WIDTH  lane 1 head word.
- Dalja1Valid  out  1  lane 1 FIFO not empty.
- Dalja1Ready  in  1  lane 1 consumer takes the head word.
- Count0  out  CNT_W  words accepted into lane 0 since reset.
- Count1  out  CNT_W  words accepted into lane 1 since reset.

Behaviour:
- Reset:
  - When Reset=1 at a rising edge, all pointers, occupancies and counters go to 0.
  - FIFO storage goes to 0.
  - In the following cycle: Dalja0Valid=Dalja1Valid=0, Dalja0=Dalja1=0, Count0=Count1=0.
  - Reset takes priority over any simultaneous push or pop. Words in flight are discarded and no handshake completes in the reset cycle.
- HyrjaReady:
  - Combinational: equals NOT full(lane selected by S), where S=1 selects lane 0.
  - Does not depend on HyrjaValid or on the consumer ready inputs.
  - Held 0 while Reset=1.
- Push:
  - Occurs when HyrjaValid and HyrjaReady are both 1 at the edge.
  - Writes Hyrja to the selected lane's tail and increments its write pointer modulo DEPTH.
  - Increments that lane's counter; the counter wraps 2^CNT_W-1 -> 0 silently.
- Pop:
  - Occurs on lane k when DaljakValid and DaljakReady are both 1 at the edge.
  - Increments that lane's read pointer modulo DEPTH.
- Outputs:
  - DaljakValid = (occupancy_k != 0).
  - Daljak = storage[read pointer] of lane k, driven directly from the register, so it is valid in the same cycle.
  - Data is stable while DaljakValid=1 and DaljakReady=0.
- Latency: a word pushed at edge N is visible on Daljak with DaljakValid=1 after edge N, provided the lane was empty. There is no combinational input-to-output path.
- Lane state per lane: EMPTY (occ=0), PARTIAL (0<occ<DEPTH), FULL (occ=DEPTH).
  - Push only: occ+1.
  - Pop only: occ-1.
  - Push and pop in the same cycle: occ unchanged, and both pointers advance.
- Full lane with a pop in the same cycle: HyrjaReady stays 0 because it is based on full only. The push is not accepted and is retried next cycle; the full lane has no pass-through.
- Empty lane: a pop cannot occur because Valid=0. Daljak holds its last storage value and consumers must ignore it.
- Lane isolation: a full lane 1 never blocks a word with S=1 (lane 0). The two lanes pop independently and simultaneously.
- S may change every cycle and is only meaningful when HyrjaValid=1. Words sent to the same lane keep their order; no ordering holds across lanes.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.

Decomposition:
- Shared package holds:
  - CPU_WIDTH=24 (default for WIDTH).
  - Lane index constants LANE0_SEL=1'b1 and LANE1_SEL=1'b0, which keep the S polarity consistent with the 2:1 mux.
- One natural sub-module: demux_lane_fifo (WIDTH, DEPTH, CNT_W).
  - Contains the storage, pointers, occupancy and counter.
  - Exposes push, push_data, full, pop, head, valid and count.
- The top level instantiates it twice and contains only the S decode and the HyrjaReady mux.

Test Plan:
1. Reset: hold Reset=1 for 2 cycles with HyrjaValid=1 -> both Valid=0, Counts=0, HyrjaReady=0, no push recorded. Release Reset -> HyrjaReady=1.
2. Routing polarity and latency: push 0xABCDEF with S=1 -> Dalja0=0xABCDEF and Dalja0Valid=1 one edge later, Dalja1Valid=0, Count0=1. Push 0x123456 with S=0 -> appears on Dalja1 and Count1=1.
3. Back-pressure isolation: Dalja0Ready=0, push 0x000001 and 0x000002 with S=1 -> lane 0 FULL and HyrjaReady=0 while S=1. Switch S=0 -> HyrjaReady=1 and 0x000003 appears on lane 1.
4. Full with simultaneous pop: lane 0 full, Dalja0Ready=1 and HyrjaValid=1 with S=1 in the same cycle -> pop of 0x000001 completes, push not accepted. The next cycle the push is accepted, and the lane drains in order 0x000002 then the new word.
5. Streaming and wrap: Dalja0Ready=1, push 10 consecutive words 0x000010..0x000019 with S=1 -> the lane reaches steady state one push and one pop per cycle, no bubbles, order preserved across pointer wrap, Count0=10.
6. Reset mid-operation: lane 1 holds 2 words, assert Reset for 1 cycle -> Dalja1Valid=0 and Count1=0 next cycle. Previously stored words never reappear after new pushes.

Source files
------------

// File: rtl/demux_1to2_buffered_pkg.sv
// Shared constants for the 1:2 buffered demux: default word width, lane select
// polarity (matches the CPU's 2:1 mux) and the per-lane occupancy classification.
package demux_1to2_buffered_pkg;

    localparam int CPU_WIDTH = 24;

    localparam logic LANE0_SEL = 1'b1;
    localparam logic LANE1_SEL = 1'b0;

    typedef enum logic [1:0] {
        LANE_EMPTY   = 2'd0,
        LANE_PARTIAL = 2'd1,
        LANE_FULL    = 2'd2
    } lane_state_e;

    function automatic lane_state_e lane_state(input int occ, input int depth);
        if (occ == 0)
            return LANE_EMPTY;
        else if (occ >= depth)
            return LANE_FULL;
        else
            return LANE_PARTIAL;
    endfunction

endpackage

// File: rtl/demux_lane_fifo.sv
// One consumer lane: DEPTH-entry FIFO with valid/ready on both sides and a
// wrapping count of accepted words. Head word comes straight from storage.
module demux_lane_fifo
    import demux_1to2_buffered_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ;
    logic [CNT_W-1:0] cnt;
    lane_state_e      state;
    logic             push_fire;
    logic             pop_fire;

    always_comb state = lane_state(int'(occ), DEPTH);

    // Full is judged before any same-cycle pop, so a full lane never passes through.
    assign full      = (state == LANE_FULL);
    assign valid     = (state != LANE_EMPTY);
    assign push_fire = push & ~full;
    assign pop_fire  = pop & valid;
    assign head      = mem[rd_ptr];
    assign count     = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            cnt    <= '0;
        end else begin
            if (push_fire) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
                cnt         <= cnt + 1'b1;
            end
            if (pop_fire)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/demux_1to2_buffered.sv
// Steers one producer stream into two buffered consumer lanes by S; a stalled
// lane only back-pressures words aimed at it.
module demux_1to2_buffered
    import demux_1to2_buffered_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Hyrja,
    input  logic             HyrjaValid,
    output logic             HyrjaReady,
    input  logic             S,
    output logic [WIDTH-1:0] Dalja0,
    output logic             Dalja0Valid,
    input  logic             Dalja0Ready,
    output logic [WIDTH-1:0] Dalja1,
    output logic             Dalja1Valid,
    input  logic             Dalja1Ready,
    output logic [CNT_W-1:0] Count0,
    output logic [CNT_W-1:0] Count1
);

    logic sel0;
    logic full0;
    logic full1;
    logic push0;
    logic push1;

    assign sel0       = (S == LANE0_SEL);
    assign HyrjaReady = ~Reset & (sel0 ? ~full0 : ~full1);
    assign push0      = HyrjaValid & HyrjaReady & sel0;
    assign push1      = HyrjaValid & HyrjaReady & ~sel0;

    demux_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_lane0 (
        .clk       (Clock),
        .rst       (Reset),
        .push      (push0),
        .push_data (Hyrja),
        .full      (full0),
        .pop       (Dalja0Ready),
        .head      (Dalja0),
        .valid     (Dalja0Valid),
        .count     (Count0)
    );

    demux_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_lane1 (
        .clk       (Clock),
        .rst       (Reset),
        .push      (push1),
        .push_data (Hyrja),
        .full      (full1),
        .pop       (Dalja1Ready),
        .head      (Dalja1),
        .valid     (Dalja1Valid),
        .count     (Count1)
    );

endmodule
